rsa_stream_wrapper: RTL and testbench

//  Byte-stream front end for the RSA-256 core. Collects modulus n, exponent d and

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/rsa_byte_shifter.sv | 41 ++++
 rtl/rsa_stream_wrapper.sv | 154 +++++++++++++++
 tb/tb_rsa_stream_wrapper.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// ============================================================================
// Module   : rsa_pkg
// Brief    : Shared widths and FSM state encoding for the RSA-256 stream path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rsa_pkg;

    localparam int RSA_WIDTH = 256;
    localparam int RSA_BYTES = RSA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_GET_KEY  = 3'd0,
        S_GET_DATA = 3'd1,
        S_START    = 3'd2,
        S_WAIT     = 3'd3,
        S_SEND     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rsa_byte_shifter.sv
// ============================================================================
// Module   : rsa_byte_shifter
// Brief    : Operand register with parallel load, byte shift-in at the low end
//            and a byte tap at the top of the low TAP_BYTES bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rsa_byte_shifter #(
    parameter int WIDTH     = 256,
    parameter int TAP_BYTES = WIDTH / 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_q,
    output logic [7:0]       o_tap
);

    logic [WIDTH-1:0] data_q;

    // Load has priority; a shift with a zero byte doubles as shift-out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
        end else if (i_load) begin
            data_q <= i_load_data;
        end else if (i_shift) begin
            data_q <= {data_q[WIDTH-9:0], i_byte};
        end
    end

    assign o_q   = data_q;
    assign o_tap = data_q[TAP_BYTES*8-1 -: 8];

endmodule

`default_nettype wire

// File: rtl/rsa_stream_wrapper.sv
// ============================================================================
// Module   : rsa_stream_wrapper
// Brief    : Byte-stream front end for the RSA core: loads key and ciphertext,
//            starts the core, and streams the result back out as bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rsa_stream_wrapper
    import rsa_pkg::*;
#(
    parameter int WIDTH     = RSA_WIDTH,
    parameter int OUT_BYTES = 31
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    input  logic             i_key_reload,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_core_start,
    output logic [WIDTH-1:0] o_core_a,
    output logic [WIDTH-1:0] o_core_d,
    output logic [WIDTH-1:0] o_core_n,
    input  logic [WIDTH-1:0] i_core_result,
    input  logic             i_core_finished
);

    localparam int              c_BYTES    = WIDTH / 8;
    localparam int              c_CW       = $clog2(2 * c_BYTES + 1);
    localparam logic [c_CW-1:0] c_N_LAST   = c_CW'(c_BYTES - 1);
    localparam logic [c_CW-1:0] c_D_LAST   = c_CW'(2 * c_BYTES - 1);
    localparam logic [c_CW-1:0] c_OUT_LAST = c_CW'(OUT_BYTES - 1);

    state_t          state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic            rx_ready_q, tx_valid_q, start_q;

    logic w_rx_fire, w_tx_fire, w_reload;
    logic w_shift_n, w_shift_d, w_shift_a, w_load_res, w_shift_res;

    logic [WIDTH-1:0] unused_res;
    logic [7:0]       unused_tap_n, unused_tap_d, unused_tap_a;

    assign w_rx_fire = i_rx_valid && rx_ready_q;
    assign w_tx_fire = tx_valid_q && i_tx_ready;
    assign w_reload  = (state_q == S_GET_DATA) && (cnt_q == '0) && i_key_reload;

    // A byte arriving with the reload pulse is the first byte of the new n.
    assign w_shift_n   = w_rx_fire && (((state_q == S_GET_KEY) && (cnt_q <= c_N_LAST)) || w_reload);
    assign w_shift_d   = w_rx_fire && (state_q == S_GET_KEY) && (cnt_q > c_N_LAST);
    assign w_shift_a   = w_rx_fire && (state_q == S_GET_DATA) && !w_reload;
    assign w_load_res  = (state_q == S_WAIT) && i_core_finished;
    assign w_shift_res = (state_q == S_SEND) && w_tx_fire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_GET_KEY: begin
                if (w_rx_fire) begin
                    if (cnt_q == c_D_LAST) begin
                        state_d = S_GET_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            S_GET_DATA: begin
                if (w_reload) begin
                    state_d = S_GET_KEY;
                    cnt_d   = w_rx_fire ? c_CW'(1) : '0;
                end else if (w_rx_fire) begin
                    if (cnt_q == c_N_LAST) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_finished) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (w_tx_fire) begin
                    if (cnt_q == c_OUT_LAST) begin
                        state_d = S_GET_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_GET_KEY;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_GET_KEY;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= (state_d == S_GET_KEY) || (state_d == S_GET_DATA);
            tx_valid_q <= (state_d == S_SEND);
            start_q    <= (state_d == S_START);
        end
    end

    rsa_byte_shifter #(.WIDTH(WIDTH), .TAP_BYTES(c_BYTES)) u_reg_n (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(1'b0), .i_load_data('0),
        .i_shift(w_shift_n), .i_byte(i_rx_data), .o_q(o_core_n), .o_tap(unused_tap_n)
    );

    rsa_byte_shifter #(.WIDTH(WIDTH), .TAP_BYTES(c_BYTES)) u_reg_d (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(1'b0), .i_load_data('0),
        .i_shift(w_shift_d), .i_byte(i_rx_data), .o_q(o_core_d), .o_tap(unused_tap_d)
    );

    rsa_byte_shifter #(.WIDTH(WIDTH), .TAP_BYTES(c_BYTES)) u_reg_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(1'b0), .i_load_data('0),
        .i_shift(w_shift_a), .i_byte(i_rx_data), .o_q(o_core_a), .o_tap(unused_tap_a)
    );

    rsa_byte_shifter #(.WIDTH(WIDTH), .TAP_BYTES(OUT_BYTES)) u_reg_res (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(w_load_res), .i_load_data(i_core_result),
        .i_shift(w_shift_res), .i_byte(8'h00), .o_q(unused_res), .o_tap(o_tx_data)
    );

    assign o_rx_ready   = rx_ready_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_core_start = start_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_stream_wrapper.sv
// ============================================================================
// Module   : tb_rsa_stream_wrapper
// Brief    : Scoreboard bench for rsa_stream_wrapper with a modexp core stub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rsa_stream_wrapper;

    typedef struct {
        logic [255:0] a;
        logic [255:0] d;
        logic [255:0] n;
    } core_exp_t;

    logic         clk;
    logic         i_rst;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic         o_rx_ready;
    logic         reload_main, reload_stub;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;
    logic         o_core_start;
    logic [255:0] o_core_a, o_core_d, o_core_n;
    logic [255:0] i_core_result;
    logic         i_core_finished;

    int n_cmp = 0;
    int n_bad = 0;
    int got_bytes = 0;
    int exp_bytes = 0;
    int starts = 0;
    int gap_max = 0;
    bit toggle_mode = 0;
    bit reload_in_wait = 0;
    bit hold_pending = 0;
    logic [7:0] held_byte;

    logic [7:0] sb_q[$];
    core_exp_t  exp_core_q[$];

    rsa_stream_wrapper dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .i_key_reload(reload_main | reload_stub),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d),
        .o_core_n(o_core_n), .i_core_result(i_core_result), .i_core_finished(i_core_finished)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                            input logic [255:0] n);
        longint unsigned b, e, m, r;
        m = n[63:0];
        if (m == 0) return '0;
        b = a[63:0] % m;
        e = d[63:0];
        r = 1 % m;
        while (e != 0) begin
            if ((e & 1) != 0) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return {192'd0, r};
    endfunction

    // Sink ready: always high, or alternating every cycle.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            i_tx_ready = toggle_mode ? !i_tx_ready : 1'b1;
        end
    end

    // Monitor: pops one expected byte per transfer, checks hold while stalled.
    always @(negedge clk) begin
        if (i_rst) begin
            hold_pending = 0;
        end else if (o_tx_valid) begin
            if (hold_pending) chk("tx_hold", {248'd0, o_tx_data}, {248'd0, held_byte});
            if (i_tx_ready) begin
                hold_pending = 0;
                got_bytes++;
                if (sb_q.size() == 0) chk("tx_extra_byte", 256'd1, 256'd0);
                else chk("tx_byte", {248'd0, o_tx_data}, {248'd0, sb_q.pop_front()});
            end else begin
                hold_pending = 1;
                held_byte    = o_tx_data;
            end
        end else if (hold_pending) begin
            hold_pending = 0;
            chk("tx_valid_dropped", 256'd0, 256'd1);
        end
    end

    // Core stub: finished 10 cycles after start with a^d mod n.
    initial begin
        core_exp_t ce;
        bit bad_rdy, bad_ops, bad_start;
        i_core_finished = 1'b0;
        i_core_result   = '0;
        reload_stub     = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!i_rst && o_core_start) begin
                starts++;
                if (exp_core_q.size() == 0) begin
                    chk("unexpected_start", 256'd1, 256'd0);
                    ce = '{a: o_core_a, d: o_core_d, n: o_core_n};
                end else begin
                    ce = exp_core_q.pop_front();
                    chk("core_a", o_core_a, ce.a);
                    chk("core_d", o_core_d, ce.d);
                    chk("core_n", o_core_n, ce.n);
                end
                bad_rdy = 0; bad_ops = 0; bad_start = 0;
                for (int k = 0; k < 9; k++) begin
                    @(posedge clk); #1;
                    if (o_rx_ready || o_tx_valid) bad_rdy = 1;
                    if (o_core_start) bad_start = 1;
                    if (o_core_a !== ce.a || o_core_d !== ce.d || o_core_n !== ce.n) bad_ops = 1;
                    if (reload_in_wait && k == 2) reload_stub = 1'b1;
                    if (k == 3) begin
                        reload_stub    = 1'b0;
                        reload_in_wait = 0;
                    end
                end
                chk("rx_ready_in_wait", {255'd0, bad_rdy}, 256'd0);
                chk("start_single_cycle", {255'd0, bad_start}, 256'd0);
                chk("core_ops_stable", {255'd0, bad_ops}, 256'd0);
                i_core_result   = modexp(o_core_a, o_core_d, o_core_n);
                i_core_finished = 1'b1;
                @(posedge clk); #1;
                i_core_finished = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  t;
        bit  rdy;
        t = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = o_rx_ready;
            @(posedge clk); #1;
            t++;
        end while (!rdy && t < 500);
        if (!rdy) chk("rx_ready_timeout", 256'd0, 256'd1);
        if (gap_max > 0) begin
            int g;
            g = $urandom_range(0, gap_max);
            i_rx_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_word(input logic [255:0] w);
        for (int i = 31; i >= 0; i--) send_byte(w[i*8 +: 8]);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 256'd0, 256'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic run_block(input logic [255:0] a, input logic [255:0] res,
                             input logic [255:0] n, input logic [255:0] d);
        exp_core_q.push_back('{a: a, d: d, n: n});
        for (int i = 30; i >= 0; i--) sb_q.push_back(res[i*8 +: 8]);
        exp_bytes += 31;
        send_word(a);
        wait_drain();
    endtask

    initial begin
        i_rst       = 1'b1;
        i_rx_data   = 8'h00;
        i_rx_valid  = 1'b0;
        reload_main = 1'b0;
        #4;
        chk("rst_rx_ready", {255'd0, o_rx_ready}, 256'd0);
        chk("rst_tx_valid", {255'd0, o_tx_valid}, 256'd0);
        chk("rst_tx_data", {248'd0, o_tx_data}, 256'd0);
        chk("rst_core_start", {255'd0, o_core_start}, 256'd0);
        chk("rst_core_n", o_core_n, 256'd0);
        chk("rst_core_a", o_core_a, 256'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        // Key 221/20, then blocks under the same key.
        send_word(256'd221);
        send_word(256'd20);
        chk("key_n", o_core_n, 256'd221);
        chk("key_d", o_core_d, 256'd20);
        run_block(256'd5, 256'd183, 256'd221, 256'd20);   // 5^20 mod 221 = 183
        run_block(256'd2, 256'd152, 256'd221, 256'd20);   // 2^20 mod 221 = 152

        toggle_mode = 1;
        run_block(256'd5, 256'd183, 256'd221, 256'd20);
        toggle_mode = 0;

        // Reload during WAIT must not disturb the key.
        reload_in_wait = 1;
        run_block(256'd2, 256'd152, 256'd221, 256'd20);

        gap_max = 4;
        run_block(256'd7, 256'd55, 256'd221, 256'd20);    // 7^20 mod 221 = 55
        gap_max = 0;

        // Async reset in the middle of loading a.
        for (int i = 31; i >= 15; i--) send_byte(8'h00);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst_rx_ready", {255'd0, o_rx_ready}, 256'd0);
        chk("midrst_core_n", o_core_n, 256'd0);
        chk("midrst_core_d", o_core_d, 256'd0);
        chk("midrst_tx_valid", {255'd0, o_tx_valid}, 256'd0);
        i_rx_valid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        send_word(256'd221);
        send_word(256'd20);
        run_block(256'd3, 256'd217, 256'd221, 256'd20);   // 3^20 mod 221 = 217

        // Reload in idle S_GET_DATA, new key 143/7.
        reload_main = 1'b1;
        @(posedge clk); #1;
        reload_main = 1'b0;
        send_word(256'd143);
        send_word(256'd7);
        chk("newkey_n", o_core_n, 256'd143);
        chk("newkey_d", o_core_d, 256'd7);
        run_block(256'd3, 256'd42, 256'd143, 256'd7);     // 3^7 mod 143 = 42

        chk("total_tx_bytes", 256'(got_bytes), 256'(exp_bytes));
        chk("total_starts", 256'(starts), 256'd7);
        chk("sb_empty", 256'(sb_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
